// File: rtl/wb_pkg.sv
// Shared opcode constants, write-source and FSM state types for the writeback controller.
package wb_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {WB_PC4, WB_ALU, WB_IMM, WB_MEM, WB_NONE} wb_src_e;

  typedef enum logic [1:0] {S_IDLE, S_MEM_REQ, S_MEM_WAIT, S_WB} state_e;

  function automatic wb_src_e wb_src(input logic [6:0] op);
    case (op)
      OP_JAL, OP_JALR:          return WB_PC4;
      OP_AUIPC, OP_OPIMM, OP_OP: return WB_ALU;
      OP_LUI:                   return WB_IMM;
      OP_LOAD:                  return WB_MEM;
      default:                  return WB_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load-data extender: keeps the low 8*2^size bits, sign- or zero-extends the rest.
module wb_load_ext #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      2'd0: begin
        if (unsigned_i) data_o = XLEN'(data_i[7:0]);
        else            data_o = XLEN'($signed(data_i[7:0]));
      end
      2'd1: begin
        if (unsigned_i) data_o = XLEN'(data_i[15:0]);
        else            data_o = XLEN'($signed(data_i[15:0]));
      end
      2'd2: begin
        if (unsigned_i) data_o = XLEN'(data_i[31:0]);
        else            data_o = XLEN'($signed(data_i[31:0]));
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: accepts one instruction, optionally issues a load, then retires it
// with a single register-file write cycle.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   imm,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [1:0]        mem_req_size,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              done
);

  localparam logic [1:0] MAX_SIZE = (XLEN == 64) ? 2'd3 : 2'd2;

  state_e              state_q;
  logic [6:0]          opcode_q;
  logic [2:0]          funct3_q;
  logic [REG_AW-1:0]   rd_q;
  logic [XLEN-1:0]     pc_q;
  logic [XLEN-1:0]     alu_q;
  logic [XLEN-1:0]     imm_q;
  logic [XLEN-1:0]     mem_q;

  logic [1:0]          size;
  logic [XLEN-1:0]     ext_data;
  logic [XLEN-1:0]     wdata_sel;
  wb_src_e             src;

  assign size = (funct3_q[1:0] > MAX_SIZE) ? MAX_SIZE : funct3_q[1:0];

  wb_load_ext #(.XLEN(XLEN)) u_ext (
    .size_i     (size),
    .unsigned_i (funct3_q[2]),
    .data_i     (mem_rsp_data),
    .data_o     (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      pc_q     <= '0;
      alu_q    <= '0;
      imm_q    <= '0;
      mem_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            opcode_q <= opcode;
            funct3_q <= funct3;
            rd_q     <= rd;
            pc_q     <= pc;
            alu_q    <= alu_result;
            imm_q    <= imm;
            state_q  <= (opcode == OP_LOAD) ? S_MEM_REQ : S_WB;
          end
        end
        S_MEM_REQ: if (mem_req_ready) state_q <= S_MEM_WAIT;
        S_MEM_WAIT: begin
          if (mem_rsp_valid) begin
            mem_q   <= ext_data;
            state_q <= S_WB;
          end
        end
        S_WB:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so they are glitch-free relative to the inputs.
  assign src = wb_src(opcode_q);

  always_comb begin
    wdata_sel = '0;
    case (src)
      WB_PC4:  wdata_sel = pc_q + XLEN'(4);
      WB_ALU:  wdata_sel = alu_q;
      WB_IMM:  wdata_sel = imm_q;
      WB_MEM:  wdata_sel = mem_q;
      default: wdata_sel = '0;
    endcase
  end

  assign in_ready      = (state_q == S_IDLE);
  assign done          = (state_q == S_WB);
  assign rf_we         = done && (src != WB_NONE) && (rd_q != '0);
  assign rf_waddr      = rf_we ? rd_q : '0;
  assign rf_wdata      = rf_we ? wdata_sel : '0;
  assign mem_req_valid = (state_q == S_MEM_REQ);
  assign mem_req_addr  = mem_req_valid ? alu_q : '0;
  assign mem_req_size  = mem_req_valid ? size : '0;

endmodule

// File: tb/tb_wb_ctrl.sv
// Randomised scoreboard bench for wb_ctrl with directed corner cases up front.
module tb_wb_ctrl;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_OPIMM = 7'b0010011;
  localparam logic [6:0] T_AUIPC = 7'b0010111;
  localparam logic [6:0] T_OP    = 7'b0110011;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_JALR  = 7'b1100111;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_BR    = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic [31:0] imm;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [1:0]  mem_req_size;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done;

  int unsigned pass_cnt = 0;
  int unsigned tot_cnt  = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wr_t;
  wr_t sb[$];

  wb_ctrl #(.XLEN(32), .REG_AW(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .funct3        (funct3),
    .rd            (rd),
    .pc            (pc),
    .alu_result    (alu_result),
    .imm           (imm),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_size  (mem_req_size),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [1:0] model_size(input logic [2:0] f3);
    return (f3[1:0] > 2'd2) ? 2'd2 : f3[1:0];
  endfunction

  // Arithmetic reference: truncate to the access width, then fold negative values into 2^32.
  function automatic logic [31:0] model_ext(input logic [31:0] d, input logic [2:0] f3);
    longint unsigned span, v;
    span = 64'd1 << (8 * (1 << model_size(f3)));
    v = longint'(d) % span;
    if (!f3[2] && v >= span / 2) v = v + (64'd1 << 32) - span;
    return v[31:0];
  endfunction

  function automatic wr_t model_wr(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [4:0] rd_v, input logic [31:0] pc_v,
                                   input logic [31:0] alu_v, input logic [31:0] imm_v,
                                   input logic [31:0] rdata);
    wr_t e;
    longint unsigned v;
    bit writes;
    writes = 1'b1;
    case (op)
      T_JAL, T_JALR:        v = (longint'(pc_v) + 4) % (64'd1 << 32);
      T_AUIPC, T_OPIMM, T_OP: v = alu_v;
      T_LUI:                v = imm_v;
      T_LOAD:               v = model_ext(rdata, f3);
      default: begin writes = 1'b0; v = 0; end
    endcase
    e.we    = writes && (rd_v != 0);
    e.waddr = e.we ? rd_v : 5'd0;
    e.wdata = e.we ? v[31:0] : 32'd0;
    return e;
  endfunction

  task automatic drive_accept(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd_v,
                              input logic [31:0] pc_v, input logic [31:0] alu_v,
                              input logic [31:0] imm_v, output bit acc);
    int unsigned n;
    opcode = op; funct3 = f3; rd = rd_v; pc = pc_v; alu_result = alu_v; imm = imm_v;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    opcode = 7'($urandom); funct3 = 3'($urandom); rd = 5'($urandom);
    pc = $urandom; alu_result = $urandom; imm = $urandom;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd_v,
                       input logic [31:0] pc_v, input logic [31:0] alu_v, input logic [31:0] imm_v,
                       input logic [31:0] rdata, input int unsigned hold, input int unsigned dly,
                       input bit stray);
    bit acc;
    drive_accept(op, f3, rd_v, pc_v, alu_v, imm_v, acc);
    if (!acc) return;
    sb.push_back(model_wr(op, f3, rd_v, pc_v, alu_v, imm_v, rdata));
    if (op == T_LOAD) begin
      for (int unsigned c = 0; c < hold; c++) begin
        check("req_valid_hold", mem_req_valid, 1);
        check("req_addr_hold", mem_req_addr, alu_v);
        check("req_size_hold", mem_req_size, model_size(f3));
        if (stray && c == 0) mem_rsp_valid = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
      end
      check("req_valid", mem_req_valid, 1);
      check("req_addr", mem_req_addr, alu_v);
      check("req_size", mem_req_size, model_size(f3));
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      check("req_drop", mem_req_valid, 0);
      for (int unsigned c = 0; c < dly; c++) begin
        check("wait_no_done", done, 0);
        @(posedge clk); #1;
      end
      mem_rsp_data  = rdata;
      mem_rsp_valid = 1'b1;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    check("done_latency", done, 1);
    @(posedge clk); #1;
    check("ready_after_wb", in_ready, 1);
  endtask

  // Monitor: every retire pops one expected write; between retires no write may appear.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("rf_we", rf_we, e.we);
          check("rf_waddr", rf_waddr, e.waddr);
          check("rf_wdata", rf_wdata, e.wdata);
        end
      end else begin
        check("no_write_idle", {rf_we, rf_waddr, rf_wdata}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [6:0] ops [10];
    logic [6:0] op;
    logic [31:0] pcv;
    ops = '{T_JAL, T_JALR, T_AUIPC, T_OPIMM, T_OP, T_LUI, T_LOAD, T_STORE, T_BR, 7'h00};

    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct3 = '0; rd = '0;
    pc = '0; alu_result = '0; imm = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_done", done, 0);
    check("rst_rf", {rf_we, rf_waddr, rf_wdata}, 0);
    check("rst_mem_req", {mem_req_valid, mem_req_addr, mem_req_size}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(T_LUI,  3'd0, 5'd5, 32'h0000_1000, 32'h0, 32'h1234_5000, 32'h0, 0, 0, 0);
    issue(T_JAL,  3'd0, 5'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    issue(T_LOAD, 3'b000, 5'd3, 32'h0, 32'h0000_0100, 32'h0, 32'h0000_0080, 0, 0, 0);
    issue(T_LOAD, 3'b100, 5'd4, 32'h0, 32'h0000_0104, 32'h0, 32'h0000_0080, 0, 0, 0);
    issue(T_LOAD, 3'b001, 5'd6, 32'h0, 32'h0000_0108, 32'h0, 32'h0000_8001, 0, 1, 0);
    issue(T_LOAD, 3'b010, 5'd7, 32'h0, 32'hDEAD_BEE0, 32'h0, 32'hCAFE_F00D, 4, 2, 1);
    issue(T_OPIMM, 3'd0, 5'd0, 32'h0, 32'h0000_0055, 32'h0, 32'h0, 0, 0, 0);
    issue(T_STORE, 3'd2, 5'd9, 32'h0, 32'h0000_0200, 32'h0, 32'h0, 0, 0, 0);

    // Reset while waiting for load data: the response that follows must be dropped.
    drive_accept(T_LOAD, 3'b010, 5'd8, 32'h0, 32'h0000_0300, 32'h0, acc);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check("rstmid_in_wait", {mem_req_valid, in_ready}, 0);
    rst_n = 1'b0;
    #1;
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_outputs", {done, rf_we, mem_req_valid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rsp_data  = 32'h1111_2222;
    mem_rsp_valid = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    check("rstmid_late_rsp", {done, rf_we}, 0);
    check("rstmid_ready_after", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 9)];
      if (op == 7'h00) op = 7'($urandom);
      pcv = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      issue(op, 3'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            pcv, $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
